// File: rtl/pwm_capture.sv
// pwm_capture: APB slave that measures high time and period of a PWM/servo
// pulse train in PCLK cycles, with timeout and overrun flags and a level IRQ.
module pwm_capture #(
  parameter int CNT_W   = 20,
  parameter int TIMEOUT = 400000
) (
  input  logic        PCLK,
  input  logic        PRESETN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        PWMIN,
  output logic        CAPINT
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARM     = 2'd1;
  localparam logic [1:0] HIGH_PH = 2'd2;
  localparam logic [1:0] LOW_PH  = 2'd3;

  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Counter step that sticks at the timeout value so it can never wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v >= TMO_VAL) return TMO_VAL;
    return v + CNT_ONE;
  endfunction

  logic             pwm_p0, pwm_p1, pwm_p2;
  logic             rise, fall;
  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, hi_tmp, hi_nxt;
  logic [CNT_W-1:0] high_q, period_q;
  logic             tmo_seen, tmo_seen_nxt;
  logic             res_ld, tmo_evt;
  logic             ctrl_en, ctrl_irqen;
  logic             st_valid, st_tmo, st_ovr;
  logic             wr_en;
  logic [1:0]       addr;
  logic [2:0]       w1c;
  logic             unused_bits;

  assign PREADY      = 1'b1;
  assign PSLVERR     = 1'b0;
  assign addr        = PADDR[3:2];
  assign wr_en       = PSEL & PENABLE & PWRITE;
  assign w1c         = (wr_en && addr == 2'd1) ? PWDATA[2:0] : 3'b000;
  assign unused_bits = ^{PADDR[7:4], PADDR[1:0], PWDATA[31:3]};

  // p0/p1 resynchronise PWMIN; p2 is the previous value used for edge detect.
  assign rise = pwm_p1 & ~pwm_p2;
  assign fall = ~pwm_p1 & pwm_p2;

  // Synchroniser and previous-value register; both edges see the same latency.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      pwm_p0 <= 1'b0;
      pwm_p1 <= 1'b0;
      pwm_p2 <= 1'b0;
    end else begin
      pwm_p0 <= PWMIN;
      pwm_p1 <= pwm_p0;
      pwm_p2 <= pwm_p1;
    end
  end

  // Measurement FSM next state, counter step, result load and timeout events.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    hi_nxt       = hi_tmp;
    tmo_seen_nxt = tmo_seen;
    res_ld       = 1'b0;
    tmo_evt      = 1'b0;
    if (!ctrl_en) begin
      state_nxt    = IDLE;
      cnt_nxt      = '0;
      hi_nxt       = '0;
      tmo_seen_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt    = ARM;
          cnt_nxt      = '0;
          tmo_seen_nxt = 1'b0;
        end
        ARM: begin
          if (rise) begin
            state_nxt    = HIGH_PH;
            cnt_nxt      = CNT_ONE;
            tmo_seen_nxt = 1'b0;
          end else begin
            cnt_nxt = sat_inc(cnt);
            // Saturated counter stays at TIMEOUT, so flag only the first hit.
            if (cnt == TMO_VAL && !tmo_seen) begin
              tmo_evt      = 1'b1;
              tmo_seen_nxt = 1'b1;
            end
          end
        end
        HIGH_PH: begin
          if (fall) begin
            state_nxt = LOW_PH;
            hi_nxt    = cnt;
            cnt_nxt   = sat_inc(cnt);
          end else if (cnt == TMO_VAL) begin
            state_nxt    = ARM;
            tmo_evt      = 1'b1;
            tmo_seen_nxt = 1'b1;
          end else begin
            cnt_nxt = sat_inc(cnt);
          end
        end
        LOW_PH: begin
          // A rise coinciding with the timeout wins: it completes the period.
          if (rise) begin
            state_nxt = HIGH_PH;
            res_ld    = 1'b1;
            cnt_nxt   = CNT_ONE;
          end else if (cnt == TMO_VAL) begin
            state_nxt    = ARM;
            tmo_evt      = 1'b1;
            tmo_seen_nxt = 1'b1;
          end else begin
            cnt_nxt = sat_inc(cnt);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM, counter and captured high time.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state    <= IDLE;
      cnt      <= '0;
      hi_tmp   <= '0;
      tmo_seen <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      hi_tmp   <= hi_nxt;
      tmo_seen <= tmo_seen_nxt;
    end
  end

  // Control and status registers plus result registers; flag set beats W1C.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      ctrl_en    <= 1'b0;
      ctrl_irqen <= 1'b0;
      st_valid   <= 1'b0;
      st_tmo     <= 1'b0;
      st_ovr     <= 1'b0;
      high_q     <= '0;
      period_q   <= '0;
    end else begin
      if (wr_en && addr == 2'd0) begin
        ctrl_en    <= PWDATA[0];
        ctrl_irqen <= PWDATA[1];
      end
      st_valid <= (st_valid & ~w1c[0]) | res_ld;
      st_tmo   <= (st_tmo & ~w1c[1]) | tmo_evt;
      st_ovr   <= (st_ovr & ~w1c[2]) | (res_ld & st_valid);
      if (res_ld) begin
        high_q   <= hi_tmp;
        period_q <= cnt;
      end
    end
  end

  // Registered level interrupt, one cycle behind the flags.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) CAPINT <= 1'b0;
    else          CAPINT <= ctrl_irqen & (st_valid | st_tmo);
  end

  // Combinational read mux, active only for read transfers.
  always_comb begin
    PRDATA = 32'h0;
    if (PSEL && !PWRITE) begin
      case (addr)
        2'd0:    PRDATA = {30'h0, ctrl_irqen, ctrl_en};
        2'd1:    PRDATA = {29'h0, st_ovr, st_tmo, st_valid};
        2'd2:    PRDATA = {{(32-CNT_W){1'b0}}, high_q};
        default: PRDATA = {{(32-CNT_W){1'b0}}, period_q};
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed + randomized pulse trains against an edge-time model.
module tb_pwm_capture;

  localparam int CNT_W = 20;
  localparam int TMO   = 5000;

  logic        PCLK = 1'b0;
  logic        PRESETN = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [7:0]  PADDR = 8'h0;
  logic [31:0] PWDATA = 32'h0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, CAPINT;
  logic        PWMIN = 1'b0;

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PWMIN(PWMIN), .CAPINT(CAPINT)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: works on input edge times only.
  bit m_en, m_irq, m_valid, m_tmo, m_ovr, m_have_rise, m_have_fall;
  int m_high, m_period, m_last_rise, m_hi;

  function automatic void model_rise(input int t);
    if (!m_en) return;
    if (m_have_rise && (t - m_last_rise) > TMO) begin
      m_tmo = 1'b1;
      m_have_rise = 1'b0;
    end
    if (m_have_rise && m_have_fall) begin
      m_high   = m_hi;
      m_period = t - m_last_rise;
      if (m_valid) m_ovr = 1'b1;
      m_valid = 1'b1;
    end
    m_have_rise = 1'b1;
    m_have_fall = 1'b0;
    m_last_rise = t;
  endfunction

  function automatic void model_fall(input int t);
    if (m_en && m_have_rise) begin
      m_have_fall = 1'b1;
      m_hi = t - m_last_rise;
    end
  endfunction

  // Input edge reaches the measurement logic 3 clocks later; timeout follows TMO clocks after that.
  function automatic void model_settle(input int t);
    if (m_en && m_have_rise && t >= m_last_rise + 3 + TMO) begin
      m_tmo = 1'b1;
      m_have_rise = 1'b0;
      m_have_fall = 1'b0;
    end
  endfunction

  function automatic void model_write(input logic [1:0] a, input logic [31:0] v);
    if (a == 2'd0) begin
      m_en  = v[0];
      m_irq = v[1];
      if (!m_en) begin
        m_have_rise = 1'b0;
        m_have_fall = 1'b0;
      end
    end else if (a == 2'd1) begin
      if (v[0]) m_valid = 1'b0;
      if (v[1]) m_tmo   = 1'b0;
      if (v[2]) m_ovr   = 1'b0;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = {4'h0, a, 2'b00};
    #1;
    d = PRDATA;
    PSEL = 1'b0; PENABLE = 1'b0; PADDR = 8'h0;
  endtask

  // Called at a negedge; the write lands on the second following posedge.
  task automatic wr(input logic [1:0] a, input logic [31:0] v, input bit upd);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = {4'h0, a, 2'b00}; PWDATA = v;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h0; PWDATA = 32'h0;
    if (upd) model_write(a, v);
    @(negedge PCLK);
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic rise_edge(input bit upd);
    PWMIN = 1'b1;
    if (upd) model_rise(cyc);
  endtask

  task automatic fall_edge();
    PWMIN = 1'b0;
    model_fall(cyc);
  endtask

  task automatic chk_all(input string tag);
    logic [31:0] d;
    rd(2'd1, d); check({tag, "_status"}, d, {29'h0, m_ovr, m_tmo, m_valid});
    rd(2'd2, d); check({tag, "_high"}, d, 32'(m_high));
    rd(2'd3, d); check({tag, "_period"}, d, 32'(m_period));
    check({tag, "_capint"}, {31'h0, CAPINT}, {31'h0, m_irq & (m_valid | m_tmo)});
  endtask

  // One full pulse, then a register check while the next rise is pending.
  task automatic pulse_chk(input string tag, input int h, input int p);
    rise_edge(1'b1);
    hold(h);
    fall_edge();
    hold(p - h);
    model_settle(cyc);
    chk_all(tag);
  endtask

  initial begin
    logic [31:0] d;
    int t0, p1, p2, h, p;

    // Reset state
    hold(3);
    PRESETN = 1'b1;
    hold(1);
    rd(2'd0, d); check("rst_ctrl", d, 32'h0);
    check("rst_pready", {31'h0, PREADY}, 32'h1);
    check("rst_pslverr", {31'h0, PSLVERR}, 32'h0);
    chk_all("rst");

    // First pulse after enable yields no result
    wr(2'd0, 32'h3, 1'b1);
    rd(2'd0, d); check("ctrl_rb", d, 32'h3);
    hold(5);
    pulse_chk("first", 300, 1000);

    // Second rise: exact result and interrupt timing
    p1 = int'($urandom_range(600, 3000));
    p2 = int'($urandom_range(600, 3000));
    rise_edge(1'b1);
    repeat (2) @(posedge PCLK); #1;
    rd(2'd1, d); check("valid_pre", {31'h0, d[0]}, 32'h0);
    @(posedge PCLK); #1;
    rd(2'd1, d); check("valid_edge", {31'h0, d[0]}, {31'h0, m_valid});
    check("capint_lag", {31'h0, CAPINT}, 32'h0);
    @(posedge PCLK); #1;
    check("capint_set", {31'h0, CAPINT}, 32'h1);
    @(negedge PCLK);
    chk_all("second");
    hold(446);
    fall_edge();
    hold(p1 - 450);

    // Overrun after leaving VALID set, then W1C of VALID|OVR
    pulse_chk("ovr", 450, p2);
    wr(2'd1, 32'h5, 1'b1);
    rd(2'd1, d); check("w1c_clear", d, {29'h0, m_ovr, m_tmo, m_valid});

    // Rise lands exactly as the counter reaches TIMEOUT
    pulse_chk("gap_tmo", 100, TMO);
    pulse_chk("gap_tmo_res", 100, 1000);

    // Randomized pulse trains with occasional status clears
    for (int i = 0; i < 8; i++) begin
      h = int'($urandom_range(1, 400));
      p = h + int'($urandom_range(4, 2000));
      pulse_chk("rand", h, p);
      if ($urandom_range(0, 1) == 1) wr(2'd1, 32'($urandom_range(0, 7)), 1'b1);
    end

    // Timeout exactly TIMEOUT clocks after the last rise reaches the logic
    rise_edge(1'b1);
    hold(1);
    fall_edge();
    repeat (2) @(posedge PCLK);
    repeat (TMO - 1) @(posedge PCLK);
    #1;
    model_settle(cyc);
    rd(2'd1, d); check("tmo_before", {31'h0, d[1]}, {31'h0, m_tmo});
    @(posedge PCLK); #1;
    model_settle(cyc);
    rd(2'd1, d); check("tmo_at", {31'h0, d[1]}, {31'h0, m_tmo});
    @(negedge PCLK);
    hold(3);
    chk_all("tmo_hold");
    wr(2'd1, 32'h7, 1'b1);
    pulse_chk("rearm1", 200, 800);
    pulse_chk("rearm2", 200, 800);

    // W1C of VALID on the very edge a new result lands: the set is kept
    t0 = cyc;
    rise_edge(1'b0);
    hold(1);
    wr(2'd1, 32'h1, 1'b0);
    model_rise(t0);
    hold(10);
    rd(2'd1, d); check("w1c_collide", d, {29'h0, m_ovr, m_tmo, m_valid});
    hold(100);
    fall_edge();
    hold(500);

    // EN cleared mid high phase, then re-enabled
    rise_edge(1'b1);
    hold(50);
    wr(2'd0, 32'h2, 1'b1);
    hold(3);
    chk_all("dis");
    hold(20);
    fall_edge();
    hold(30);
    wr(2'd0, 32'h3, 1'b1);
    hold(5);
    pulse_chk("reen1", 250, 900);
    pulse_chk("reen2", 250, 900);

    // Asynchronous reset mid-cycle clears outputs without a clock edge
    @(posedge PCLK); #2;
    PRESETN = 1'b0;
    #1;
    check("arst_capint", {31'h0, CAPINT}, 32'h0);
    rd(2'd2, d); check("arst_high", d, 32'h0);
    rd(2'd1, d); check("arst_status", d, 32'h0);
    rd(2'd0, d); check("arst_ctrl", d, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
